// File: rtl/fp64_acc_pkg.sv
// Shared types and helpers for the fp64 vector-sum sequencer: FSM encoding,
// fp64 exponent field constants and the input sanitiser.
package fp64_acc_pkg;

  typedef enum logic [1:0] {
    FEED     = 2'd0,
    FLUSH    = 2'd1,
    WAIT_SUM = 2'd2,
    EMIT     = 2'd3
  } state_t;

  localparam int               FP64_EXP_LSB     = 52;
  localparam int               FP64_EXP_W       = 11;
  localparam logic [10:0]      FP64_EXP_SPECIAL = 11'h7FF;

  function automatic logic [FP64_EXP_W-1:0] fp64_exp(input logic [63:0] d);
    return d[FP64_EXP_LSB +: FP64_EXP_W];
  endfunction

  // A zero exponent covers +/-0 and every denormal; all of them become +0.0.
  function automatic logic [63:0] fp64_sanitise(input logic [63:0] d);
    if (fp64_exp(d) == '0) return 64'h0;
    return d;
  endfunction

endpackage

// File: rtl/fp64_vec_sum_ctrl.sv
// Job sequencer in front of the fp64 accumulator: streams elements, flushes the
// accumulator on tlast and emits one tagged sum per vector. Optional: FP64_SPECIAL_FLAG_EN.
module fp64_vec_sum_ctrl
  import fp64_acc_pkg::*;
#(
  parameter int CNT_WIDTH      = 16,
  parameter int ID_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [63:0]          s_tdata,
  input  logic                 s_tvalid,
  input  logic                 s_tlast,
  output logic                 s_tready,
  output logic [63:0]          acc_tdata,
  output logic                 acc_tvalid,
  input  logic                 acc_tready,
  output logic                 clr_valid,
  input  logic                 clr_ready,
  input  logic [63:0]          sum_tdata,
  input  logic                 sum_tvalid,
  output logic                 sum_tready,
  output logic [63:0]          r_tdata,
  output logic                 r_tvalid,
  input  logic                 r_tready,
  output logic [ID_WIDTH-1:0]  r_id,
  output logic [CNT_WIDTH-1:0] r_count,
  output logic                 r_err
`ifdef FP64_SPECIAL_FLAG_EN
  ,
  output logic                 r_special
`endif
);

  localparam int                TMR_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [ID_WIDTH-1:0]  r_vid;
  logic [63:0]          r_sum;
  logic                 r_res_err;
  logic [TMR_W-1:0]     r_tmr;

  logic w_beat;
  logic w_emit_done;

  assign w_beat      = (r_state == FEED) && s_tvalid && acc_tready;
  assign w_emit_done = (r_state == EMIT) && r_tready;

  assign s_tready   = (r_state == FEED) && acc_tready;
  assign acc_tvalid = (r_state == FEED) && s_tvalid;
  assign acc_tdata  = fp64_sanitise(s_tdata);
  assign clr_valid  = (r_state == FLUSH);
  assign sum_tready = (r_state == WAIT_SUM);
  assign r_tvalid   = (r_state == EMIT);
  assign r_tdata    = r_sum;
  assign r_id       = r_vid;
  assign r_count    = r_cnt;
  assign r_err      = r_res_err;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous to match the rest of the codebase.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= FEED;
      r_cnt     <= '0;
      r_vid     <= '0;
      r_sum     <= '0;
      r_res_err <= 1'b0;
      r_tmr     <= '0;
    end else begin
      case (r_state)
        FEED: begin
          if (w_beat) begin
            if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
            if (s_tlast) r_state <= FLUSH;
          end
        end
        FLUSH: begin
          if (clr_ready) begin
            r_state <= WAIT_SUM;
            r_tmr   <= TMR_LOAD;
          end
        end
        WAIT_SUM: begin
          // A sum arriving on the final timer cycle still takes priority.
          if (sum_tvalid) begin
            r_sum     <= sum_tdata;
            r_res_err <= 1'b0;
            r_state   <= EMIT;
          end else if (r_tmr == '0) begin
            r_sum     <= '0;
            r_res_err <= 1'b1;
            r_state   <= EMIT;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        EMIT: begin
          if (r_tready) begin
            r_vid   <= r_vid + 1'b1;
            r_cnt   <= '0;
            r_state <= FEED;
          end
        end
        default: r_state <= FEED;
      endcase
    end
  end

`ifdef FP64_SPECIAL_FLAG_EN
  logic r_spec;

  always_ff @(posedge clk) begin
    if (!rstn)                                             r_spec <= 1'b0;
    else if (w_emit_done)                                  r_spec <= 1'b0;
    else if (w_beat && fp64_exp(s_tdata) == FP64_EXP_SPECIAL) r_spec <= 1'b1;
  end

  assign r_special = r_spec;
`endif

endmodule

// File: tb/tb_fp64_vec_sum_ctrl.sv
// Scoreboard bench for fp64_vec_sum_ctrl: upstream driver, accumulator clear/sum
// model and result monitor; build with FP64_SPECIAL_FLAG_EN to cover r_special.
module tb_fp64_vec_sum_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [63:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [63:0] acc_tdata;
  logic        acc_tvalid;
  logic        acc_tready = 1'b1;
  logic        clr_valid;
  logic        clr_ready = 1'b1;
  logic [63:0] sum_tdata = '0;
  logic        sum_tvalid = 1'b0;
  logic        sum_tready;
  logic [63:0] r_tdata;
  logic        r_tvalid;
  logic        r_tready = 1'b1;
  logic [7:0]  r_id;
  logic [15:0] r_count;
  logic        r_err;
`ifdef FP64_SPECIAL_FLAG_EN
  logic        r_special;
`endif

  fp64_vec_sum_ctrl #(.CNT_WIDTH(16), .ID_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .acc_tdata(acc_tdata), .acc_tvalid(acc_tvalid), .acc_tready(acc_tready),
    .clr_valid(clr_valid), .clr_ready(clr_ready),
    .sum_tdata(sum_tdata), .sum_tvalid(sum_tvalid), .sum_tready(sum_tready),
    .r_tdata(r_tdata), .r_tvalid(r_tvalid), .r_tready(r_tready),
    .r_id(r_id), .r_count(r_count), .r_err(r_err)
`ifdef FP64_SPECIAL_FLAG_EN
    , .r_special(r_special)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        err;
    logic [15:0] count;
    logic [7:0]  id;
    logic        spec;
    int          lat;
  } res_t;

  typedef struct {
    bit          ret;
    int          delay;
    logic [63:0] val;
  } plan_t;

  res_t  exp_q[$];
  plan_t plan_q[$];

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         n_sent = 0;
  int         n_acc = 0;
  int         hs_cyc = 0;
  int         rise_cyc = 0;
  bit         stall_en = 1'b0;
  logic [7:0] exp_id = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_san(input logic [63:0] d);
    return (d[62:52] == 11'd0) ? 64'd0 : d;
  endfunction

  function automatic logic [63:0] rnd_elem();
    logic [63:0] d;
    int          k;
    d = {$urandom(), $urandom()};
    k = $urandom_range(0, 9);
    if (k == 0) d[62:52] = 11'd0;
    if (k == 1) d = 64'h8000_0000_0000_0000;
    if (k == 2) d[62:52] = 11'h7FF;
    return d;
  endfunction

  task automatic send_beat(input logic [63:0] d, input bit last);
    int n;
    n = 0;
    s_tdata  = d;
    s_tvalid = 1'b1;
    s_tlast  = last;
    do begin
      @(negedge clk);
      n++;
    end while (!s_tready && n < 500);
    if (!s_tready) check("beat_accept_timeout", {63'd0, s_tready}, 64'd1);
    @(posedge clk);
    #1;
    n_sent++;
  endtask

  // Push the expected result and the accumulator's reply plan, then stream the vector.
  task automatic send_vec(input logic [63:0] el[$], input bit ret, input int delay,
                          input logic [63:0] val);
    res_t  r;
    plan_t p;
    bit    sp;
    sp = 1'b0;
    foreach (el[i]) if (el[i][62:52] == 11'h7FF) sp = 1'b1;
    r.data  = ret ? val : 64'd0;
    r.err   = !ret;
    r.count = 16'(el.size());
    r.id    = exp_id;
    r.spec  = sp;
    r.lat   = ret ? delay + 1 : TO;
    exp_id  = exp_id + 8'd1;
    exp_q.push_back(r);
    p.ret   = ret;
    p.delay = delay;
    p.val   = val;
    plan_q.push_back(p);
    foreach (el[i]) send_beat(el[i], i == el.size() - 1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Ready/stall generator for the three downstream-facing handshakes.
  initial forever begin
    @(posedge clk);
    #1;
    if (stall_en) begin
      acc_tready = ($urandom_range(0, 3) != 0);
      clr_ready  = ($urandom_range(0, 2) == 0);
      r_tready   = ($urandom_range(0, 2) != 0);
    end else begin
      acc_tready = 1'b1;
      clr_ready  = 1'b1;
      r_tready   = 1'b1;
    end
  end

  // Accumulator model: on each clear handshake, reply with the planned sum (or never).
  initial begin
    plan_t p;
    int    n;
    forever begin
      @(negedge clk);
      if (rstn && clr_valid && clr_ready) begin
        hs_cyc = cyc + 1;
        if (plan_q.size() == 0) begin
          check("plan_underrun", 64'(plan_q.size()), 64'd1);
          @(posedge clk);
        end else begin
          p = plan_q.pop_front();
          @(posedge clk);
          if (p.ret) begin
            repeat (p.delay) @(posedge clk);
            #1;
            sum_tdata  = p.val;
            sum_tvalid = 1'b1;
            n = 0;
            do begin
              @(negedge clk);
              n++;
            end while (!sum_tready && n < 50);
            if (!sum_tready) check("sum_accept_timeout", {63'd0, sum_tready}, 64'd1);
            @(posedge clk);
            #1;
            sum_tvalid = 1'b0;
          end
        end
      end
    end
  end

  // Element path monitor.
  initial forever begin
    @(negedge clk);
    if (rstn) begin
      if (s_tvalid && s_tready) begin
        check("acc_tdata", acc_tdata, model_san(s_tdata));
        check("acc_tvalid", {63'd0, acc_tvalid}, 64'd1);
      end
      if (acc_tvalid && acc_tready) n_acc++;
      check("clr_acc_excl", {63'd0, clr_valid & acc_tvalid}, 64'd0);
    end
  end

  // Result monitor: hold stability, scoreboard compare and latency.
  initial begin
    res_t        e;
    logic        prev_rv, prev_rr;
    logic [63:0] snap_d;
    logic [24:0] snap_t;
    prev_rv = 1'b0;
    prev_rr = 1'b0;
    snap_d  = '0;
    snap_t  = '0;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (r_tvalid && !prev_rv) rise_cyc = cyc;
        if (r_tvalid && prev_rv && !prev_rr) begin
          check("r_hold_data", r_tdata, snap_d);
          check("r_hold_tag", 64'({r_id, r_count, r_err}), 64'(snap_t));
        end
        if (r_tvalid && r_tready) begin
          if (exp_q.size() == 0) begin
            check("r_unexpected", {63'd0, r_tvalid}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("r_tdata", r_tdata, e.data);
            check("r_err", {63'd0, r_err}, {63'd0, e.err});
            check("r_count", 64'(r_count), 64'(e.count));
            check("r_id", 64'(r_id), 64'(e.id));
            check("r_latency", 64'(rise_cyc - hs_cyc), 64'(e.lat));
`ifdef FP64_SPECIAL_FLAG_EN
            check("r_special", {63'd0, r_special}, {63'd0, e.spec});
`endif
          end
        end
        prev_rv = r_tvalid;
        prev_rr = r_tready;
        snap_d  = r_tdata;
        snap_t  = {r_id, r_count, r_err};
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] el[$];
    int          n;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_r_tvalid", {63'd0, r_tvalid}, 64'd0);
    check("rst_clr_valid", {63'd0, clr_valid}, 64'd0);
    check("rst_sum_tready", {63'd0, sum_tready}, 64'd0);
    check("rst_acc_tvalid", {63'd0, acc_tvalid}, 64'd0);
    check("rst_s_tready", {63'd0, s_tready}, {63'd0, acc_tready});
    check("rst_r_tdata", r_tdata, 64'd0);
    check("rst_r_id", 64'(r_id), 64'd0);
    check("rst_r_count", 64'(r_count), 64'd0);
    check("rst_r_err", {63'd0, r_err}, 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // 1.0 + 2.0 + 3.0, sum 6.0 returned two cycles after the clear handshake.
    el = '{64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000};
    send_vec(el, 1'b1, 2, 64'h4018_0000_0000_0000);

    // Denormal and -0 flushed, 1.0 untouched.
    el = '{64'h000F_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h3FF0_0000_0000_0000};
    send_vec(el, 1'b1, 0, 64'h3FF0_0000_0000_0000);

    // No sum returned: timeout result, then a normal vector.
    el = '{64'h4000_0000_0000_0000, 64'h4010_0000_0000_0000};
    send_vec(el, 1'b0, 0, 64'h0);
    el = '{64'h4014_0000_0000_0000};
    send_vec(el, 1'b1, 1, 64'h4014_0000_0000_0000);

    // Sum arriving exactly on the timer-0 cycle still wins.
    el = '{64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000};
    send_vec(el, 1'b1, TO - 1, 64'h4000_0000_0000_0000);

    // Two single-element vectors back to back.
    el = '{64'h4020_0000_0000_0000};
    send_vec(el, 1'b1, 0, 64'h4020_0000_0000_0000);
    el = '{64'h4022_0000_0000_0000};
    send_vec(el, 1'b1, 0, 64'h4022_0000_0000_0000);

    // NaN only in the first vector.
    el = '{64'h7FF8_0000_0000_0000, 64'h3FF0_0000_0000_0000};
    send_vec(el, 1'b1, 1, 64'h7FF8_0000_0000_0000);
    el = '{64'h4000_0000_0000_0000};
    send_vec(el, 1'b1, 1, 64'h4000_0000_0000_0000);

    // Randomised vectors with stalls on every downstream handshake; ids wrap past 255.
    stall_en = 1'b1;
    for (int v = 0; v < 300; v++) begin
      int len;
      len = $urandom_range(1, 6);
      el.delete();
      for (int i = 0; i < len; i++) el.push_back(rnd_elem());
      send_vec(el, $urandom_range(0, 19) != 0, $urandom_range(0, TO - 1),
               {$urandom(), $urandom()});
    end

    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    stall_en = 1'b0;
    repeat (2) @(posedge clk);
    check("drain_results", 64'(exp_q.size()), 64'd0);
    check("drain_plans", 64'(plan_q.size()), 64'd0);
    check("beats_forwarded", 64'(n_acc), 64'(n_sent));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
